// File: rtl/sysid_verify_pkg.sv
// sysid_verify_pkg
//   Shared definitions for the system-ID verify master: data width,
//   sysid slave word addresses and the sequencer state encoding.
package sysid_verify_pkg;

  localparam int DATA_W = 32;

  // Word addresses inside the sysid slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sysid_verify_timer.sv
// sysid_verify_timer
//   Saturating per-read cycle counter. Cleared when a read request is
//   launched, counts while enabled, and flags expiry on the last cycle a
//   read may still complete.
// Ports
//   clock   in  1  rising-edge clock
//   reset   in  1  synchronous active-high reset
//   clear   in  1  restart the count at zero on the next edge
//   enable  in  1  count this cycle
//   expire  out 1  this is the TIMEOUT_CYCLES-th cycle of the read
module sysid_verify_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX) begin
      count <= count + W'(1);
    end
  end

  // The count equals the number of cycles already spent on this read, so
  // the read has used its full budget when the count reaches LAST.
  assign expire = enable && (count >= LAST);

endmodule

// File: rtl/sysid_verify_master.sv
// sysid_verify_master
//   Avalon-MM read master that reads the sysid slave (word 0: system ID,
//   word 1: build timestamp) after reset or on a start pulse, compares the
//   words against the expected image values and reports the verdict.
// Ports
//   clock              in   1   rising-edge clock
//   reset              in   1   synchronous active-high reset
//   start              in   1   begin a check when not busy
//   avm_address        out  1   0 = ID word, 1 = timestamp word
//   avm_read           out  1   read request
//   avm_waitrequest    in   1   slave stall
//   avm_readdata       in   32  read data
//   avm_readdatavalid  in   1   read data valid
//   id_value           out  32  captured system ID
//   ts_value           out  32  captured timestamp
//   busy               out  1   check in progress
//   done               out  1   check finished (held until next start)
//   pass               out  1   no mismatch and no timeout
//   id_mismatch        out  1   captured ID differs from EXPECTED_ID
//   ts_mismatch        out  1   captured TS differs (only when CHECK_TS)
//   timeout_err        out  1   a read ran out of cycles
module sysid_verify_master
  import sysid_verify_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit                CHECK_TS       = 1'b1,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter bit                AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_mismatch,
  output logic              ts_mismatch,
  output logic              timeout_err
);

  state_t            state, state_next;
  logic              auto_pending;
  logic              launch, cap_id, cap_ts, set_timeout, finish;
  logic              timer_clear, timer_expire;
  logic [DATA_W-1:0] id_next, ts_next;
  logic              id_mm, ts_mm;

  sysid_verify_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (busy),
    .expire (timer_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    timer_clear = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    set_timeout = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start || auto_pending) begin
          launch      = 1'b1;
          timer_clear = 1'b1;
          state_next  = ST_ID_REQ;
        end
      end
      ST_ID_REQ: begin
        // Data in the accept cycle comes from a zero-latency slave.
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_id      = 1'b1;
          timer_clear = 1'b1;
          state_next  = ST_TS_REQ;
        end else if (timer_expire) begin
          set_timeout = 1'b1;
          state_next  = ST_DONE;
        end else if (!avm_waitrequest) begin
          state_next = ST_ID_WAIT;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          cap_id      = 1'b1;
          timer_clear = 1'b1;
          state_next  = ST_TS_REQ;
        end else if (timer_expire) begin
          set_timeout = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_TS_REQ: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = ST_DONE;
        end else if (timer_expire) begin
          set_timeout = 1'b1;
          state_next  = ST_DONE;
        end else if (!avm_waitrequest) begin
          state_next = ST_TS_WAIT;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = ST_DONE;
        end else if (timer_expire) begin
          set_timeout = 1'b1;
          state_next  = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign finish = (state_next == ST_DONE) && (state != ST_DONE);

  // Verdict uses the values as they will be after this edge, so a capture
  // on the final cycle is included.
  assign id_next = cap_id ? avm_readdata : id_value;
  assign ts_next = cap_ts ? avm_readdata : ts_value;
  assign id_mm   = (id_next != EXPECTED_ID);
  assign ts_mm   = CHECK_TS && (ts_next != EXPECTED_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pending <= AUTO_START;
      id_value     <= '0;
      ts_value     <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      id_mismatch  <= 1'b0;
      ts_mismatch  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      id_value <= id_next;
      ts_value <= ts_next;
      if (launch) begin
        auto_pending <= 1'b0;
        done         <= 1'b0;
        pass         <= 1'b0;
        id_mismatch  <= 1'b0;
        ts_mismatch  <= 1'b0;
        timeout_err  <= 1'b0;
      end
      if (set_timeout) timeout_err <= 1'b1;
      if (finish) begin
        done        <= 1'b1;
        id_mismatch <= id_mm;
        ts_mismatch <= ts_mm;
        pass        <= !id_mm && !ts_mm && !set_timeout;
      end
    end
  end

  assign busy        = !(state inside {ST_IDLE, ST_DONE});
  assign avm_read    = (state inside {ST_ID_REQ, ST_TS_REQ});
  assign avm_address = (state inside {ST_TS_REQ, ST_TS_WAIT}) ? SYSID_ADDR_TS
                                                              : SYSID_ADDR_ID;

endmodule

// File: tb/tb_sysid_verify_master.sv
// tb_sysid_verify_master
//   Directed and randomized checks of the sysid verify master against a
//   behavioural slave and a run-level reference model. A second instance
//   with CHECK_TS=0 shares the bus inputs and is checked for its verdict.
module tb_sysid_verify_master;

  localparam logic [31:0] EXP_ID = 32'h5BC4_1E7F;
  localparam logic [31:0] EXP_TS = 32'h0000_1234;
  localparam int          TMO    = 8;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        avm_address, avm_read, busy, done, pass;
  logic        id_mismatch, ts_mismatch, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        b_address, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_id, b_ts;

  sysid_verify_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .id_value(id_value), .ts_value(ts_value), .busy(busy), .done(done),
    .pass(pass), .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch),
    .timeout_err(timeout_err)
  );

  sysid_verify_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut_nts (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(b_address), .avm_read(b_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .id_value(b_id), .ts_value(b_ts), .busy(b_busy), .done(b_done),
    .pass(b_pass), .id_mismatch(b_idm), .ts_mismatch(b_tsm),
    .timeout_err(b_to)
  );

  always #5 clock = ~clock;

  // Slave behaviour, set by the main sequence.
  logic [31:0] s_id = EXP_ID, s_ts = EXP_TS, inj_data = '0;
  int          s_wait = 0, inj_req = 0;
  bit          s_zero = 1'b0, s_respond = 1'b1;

  // Slave bookkeeping, written only by the slave process.
  int accepted = 0, stab_err = 0, stall_cnt = 0, inj_done = 0;
  bit acc, acc_addr, was_held, held_addr;

  // Reference model of the captured words.
  logic [31:0] m_id = '0, m_ts = '0;
  int n_checks = 0, n_pass = 0;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      acc       = avm_read && !avm_waitrequest;
      acc_addr  = avm_address;
      was_held  = avm_read && avm_waitrequest;
      held_addr = avm_address;
      if (acc) accepted++;
      @(posedge clock);
      #1;
      if (was_held && !(avm_read && avm_address == held_addr)) stab_err++;
      avm_readdatavalid = 1'b0;
      if (inj_req != inj_done) begin
        inj_done          = inj_req;
        avm_readdatavalid = 1'b1;
        avm_readdata      = inj_data;
      end else if (acc && s_respond && !s_zero) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = acc_addr ? s_ts : s_id;
      end
      if (avm_read && stall_cnt < s_wait) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt       = 0;
      end
      if (avm_read && !avm_waitrequest && s_respond && s_zero) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = avm_address ? s_ts : s_id;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    bit got;
    got         = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (busy) busy_cycles++;
      if (done === 1'b1) got = 1'b1;
    end
    check("done_reached", got, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".flags"}, {id_mismatch, ts_mismatch, timeout_err}, 0);
    check({tag, ".id"}, id_value, 0);
    check({tag, ".ts"}, ts_value, 0);
    check({tag, ".busy_read_addr"}, {busy, avm_read, avm_address}, 0);
  endtask

  // Run-level model: a responding slave delivers both words, a silent one
  // times out on the ID read and leaves both captures untouched.
  task automatic check_result(input string tag, input bit timed_out);
    bit e_idm, e_tsm;
    if (!timed_out) begin
      m_id = s_id;
      m_ts = s_ts;
    end
    e_idm = (m_id != EXP_ID);
    e_tsm = (m_ts != EXP_TS);
    check({tag, ".done"}, done, 1);
    check({tag, ".id"}, id_value, m_id);
    check({tag, ".ts"}, ts_value, m_ts);
    check({tag, ".id_mm"}, id_mismatch, e_idm);
    check({tag, ".ts_mm"}, ts_mismatch, e_tsm);
    check({tag, ".timeout"}, timeout_err, timed_out);
    check({tag, ".pass"}, pass, !e_idm && !e_tsm && !timed_out);
    check({tag, ".idle_bus"}, {busy, avm_read}, 0);
    check({tag, ".nts_ts_mm"}, b_tsm, 0);
    check({tag, ".nts_pass"}, b_pass, !e_idm && !timed_out);
  endtask

  initial begin
    int bc, acc0, stab0, n, reads_after;
    bit found;
    reset = 1'b1;
    start = 1'b0;

    // Reset state.
    tick();
    tick();
    check_cleared("reset");

    // 1: automatic run against a matching image.
    acc0  = accepted;
    reset = 1'b0;
    wait_done(bc);
    check_result("auto", 1'b0);
    check("auto.busy_cycles", bc, 4);
    check("auto.reads", accepted - acc0, 2);
    reads_after = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (avm_read) reads_after++;
    end
    check("auto.read_after_done", reads_after, 0);

    // 2: ID off by one; also start-to-done latency.
    s_id  = EXP_ID ^ 32'h1;
    acc0  = accepted;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat.done_cleared", done, 0);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("lat.cycles", n, 5);
    check_result("id_bad", 1'b0);
    check("id_bad.reads", accepted - acc0, 2);

    // 3: three stall cycles on each read.
    s_id   = EXP_ID;
    s_wait = 3;
    acc0   = accepted;
    stab0  = stab_err;
    pulse_start();
    wait_done(bc);
    check_result("stall", 1'b0);
    check("stall.reads", accepted - acc0, 2);
    check("stall.stable", stab_err - stab0, 0);
    check("stall.busy_cycles", bc, 2 * (3 + 2));
    s_wait = 0;

    // 5: reset while waiting for the timestamp; start during reset loses.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && avm_address && !avm_read) found = 1'b1;
      else tick();
    end
    check("rst_mid.found_ts_wait", found, 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_id  = '0;
    m_ts  = '0;
    check_cleared("rst_mid");
    reset = 1'b0;
    wait_done(bc);
    check_result("rst_rerun", 1'b0);

    // 4: silent slave, auto-run after reset times out on the ID read.
    s_respond = 1'b0;
    reset     = 1'b1;
    tick();
    m_id  = '0;
    m_ts  = '0;
    acc0  = accepted;
    reset = 1'b0;
    wait_done(bc);
    check_result("tmo", 1'b1);
    check("tmo.busy_cycles", bc, TMO);
    check("tmo.reads", accepted - acc0, 1);
    inj_data = EXP_ID;
    inj_req++;
    for (int i = 0; i < 3; i++) tick();
    check_result("tmo_late", 1'b1);
    s_respond = 1'b1;

    // 6: timestamp differs; start while busy ignored; start in DONE reruns.
    s_ts = EXP_TS ^ ($urandom() | 32'h1);
    acc0 = accepted;
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(bc);
    check_result("ts_bad", 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("ts_bad.reads", accepted - acc0, 2);
    check("ts_bad.no_rerun", {busy, done}, 2'b01);
    pulse_start();
    check("rerun.cleared", {done, pass, id_mismatch, ts_mismatch, timeout_err}, 0);
    wait_done(bc);
    check_result("rerun", 1'b0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      s_wait = $urandom_range(0, 3);
      s_zero = 1'($urandom_range(0, 1));
      s_id   = $urandom_range(0, 1) ? EXP_ID : $urandom();
      s_ts   = $urandom_range(0, 1) ? EXP_TS : $urandom();
      acc0   = accepted;
      pulse_start();
      wait_done(bc);
      check_result($sformatf("rnd%0d", r), 1'b0);
      check($sformatf("rnd%0d.busy_cycles", r), bc, 2 * (s_wait + (s_zero ? 1 : 2)));
      check($sformatf("rnd%0d.reads", r), accepted - acc0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
